// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised horizontal + vertical VGA raster timing.
// Counters advance on pix_en; blanking, de and sync are decoded
// combinationally from the registered counters. line_start and
// frame_start are registered single-clk_in strobes.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW       = $clog2(H_TOTAL),
    localparam int unsigned VW       = $clog2(V_TOTAL)
) (
    input  logic          clk_in,
    input  logic          resetn,
    input  logic          pix_en,
    output logic [HW-1:0] h_count,
    output logic [VW-1:0] v_count,
    output logic          h_blank,
    output logic          v_blank,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic h_wrap;
    logic v_wrap;
    logic in_hsync;
    logic in_vsync;

    assign h_wrap = (h_count == H_LAST);
    assign v_wrap = (v_count == V_LAST);

    // Raster counters: reset parks on the last pixel of the frame so the
    // first enabled edge lands on (0,0).
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            h_count <= H_LAST;
            v_count <= V_LAST;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_count <= '0;
                if (v_wrap) v_count <= '0;
                else        v_count <= v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    // Start strobes: set on the enabled wrap edge, cleared on every other edge.
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= pix_en && h_wrap;
            frame_start <= pix_en && h_wrap && v_wrap;
        end
    end

    // Decodes of the registered counters, coherent with the counts.
    always_comb begin
        h_blank  = (h_count >= H_ACT_END);
        v_blank  = (v_count >= V_ACT_END);
        de       = !h_blank && !v_blank;
        in_hsync = (h_count >= H_SYNC_FIRST) && (h_count <= H_SYNC_LAST);
        in_vsync = (v_count >= V_SYNC_FIRST) && (v_count <= V_SYNC_LAST);
        hsync    = in_hsync ? HSYNC_POL : !HSYNC_POL;
        vsync    = in_vsync ? VSYNC_POL : !VSYNC_POL;
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on the small 14x7 raster.
// The reference model tracks a linear pixel index within the frame.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int NPIX = HT * VT;

    logic clk_in = 1'b0;
    logic resetn = 1'b0;
    logic pix_en = 1'b0;

    logic [3:0] a_h_count, b_h_count;
    logic [2:0] a_v_count, b_v_count;
    logic a_h_blank, a_v_blank, a_de, a_hsync, a_vsync, a_line_start, a_frame_start;
    logic b_h_blank, b_v_blank, b_de, b_hsync, b_vsync, b_line_start, b_frame_start;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut_neg (
        .clk_in(clk_in), .resetn(resetn), .pix_en(pix_en),
        .h_count(a_h_count), .v_count(a_v_count),
        .h_blank(a_h_blank), .v_blank(a_v_blank), .de(a_de),
        .hsync(a_hsync), .vsync(a_vsync),
        .line_start(a_line_start), .frame_start(a_frame_start)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_pos (
        .clk_in(clk_in), .resetn(resetn), .pix_en(pix_en),
        .h_count(b_h_count), .v_count(b_v_count),
        .h_blank(b_h_blank), .v_blank(b_v_blank), .de(b_de),
        .hsync(b_hsync), .vsync(b_vsync),
        .line_start(b_line_start), .frame_start(b_frame_start)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int h;
        int v;
        bit hb, vb, de, hs_lo, vs_lo, ls, fs;
    } exp_t;

    exp_t q_edge[$];
    exp_t q_mid[$];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: linear pixel index and strobe flags
    int p = NPIX - 1;
    bit m_ls = 0;
    bit m_fs = 0;

    function automatic exp_t expect_of(int idx, bit ls, bit fs);
        exp_t e;
        bit in_hs, in_vs;
        e.h   = idx % HT;
        e.v   = idx / HT;
        e.hb  = (e.h >= HA);
        e.vb  = (e.v >= VA);
        e.de  = !e.hb && !e.vb;
        in_hs = (e.h >= HA + HF) && (e.h < HA + HF + HS);
        in_vs = (e.v >= VA + VF) && (e.v < VA + VF + VS);
        e.hs_lo = !in_hs;
        e.vs_lo = !in_vs;
        e.ls  = ls;
        e.fs  = fs;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic check_all(input exp_t e, input string tag);
        chk({tag, ".h_count"},     32'(a_h_count),     32'(e.h));
        chk({tag, ".v_count"},     32'(a_v_count),     32'(e.v));
        chk({tag, ".h_blank"},     32'(a_h_blank),     32'(e.hb));
        chk({tag, ".v_blank"},     32'(a_v_blank),     32'(e.vb));
        chk({tag, ".de"},          32'(a_de),          32'(e.de));
        chk({tag, ".hsync"},       32'(a_hsync),       32'(e.hs_lo));
        chk({tag, ".vsync"},       32'(a_vsync),       32'(e.vs_lo));
        chk({tag, ".line_start"},  32'(a_line_start),  32'(e.ls));
        chk({tag, ".frame_start"}, 32'(a_frame_start), 32'(e.fs));
        chk({tag, ".hsync_pos"},   32'(b_hsync),       32'(!e.hs_lo));
        chk({tag, ".vsync_pos"},   32'(b_vsync),       32'(!e.vs_lo));
        chk({tag, ".h_count_pos"}, 32'(b_h_count),     32'(e.h));
        chk({tag, ".de_pos"},      32'(b_de),          32'(e.de));
        chk({tag, ".fs_pos"},      32'(b_frame_start), 32'(e.fs));
    endtask

    // Monitor: checks the post-edge state, then the state after mid-cycle drive.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (q_edge.size() != 0) check_all(q_edge.pop_front(), "edge");
            #5;
            if (q_mid.size() != 0) check_all(q_mid.pop_front(), "mid");
        end
    end

    // One cycle of stimulus, driven 3 time units after the rising edge.
    task automatic step(input bit en, input bit rn);
        @(posedge clk_in);
        #3;
        pix_en = en;
        resetn = rn;
        if (!rn) begin
            p    = NPIX - 1;
            m_ls = 0;
            m_fs = 0;
        end
        q_mid.push_back(expect_of(p, m_ls, m_fs));
        if (rn) begin
            m_ls = 0;
            m_fs = 0;
            if (en) begin
                p    = (p + 1) % NPIX;
                m_ls = (p % HT == 0);
                m_fs = (p == 0);
            end
        end
        q_edge.push_back(expect_of(p, m_ls, m_fs));
    endtask

    initial begin
        repeat (3) step(1'b0, 1'b0);
        // continuous enable: more than one full frame
        repeat (220) step(1'b1, 1'b1);
        // sparse enable, 1-of-4
        for (int i = 0; i < 400; i++) step(i % 4 == 0, 1'b1);
        // random enable with occasional resets
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 2) != 0, $urandom_range(0, 199) != 0);
        // reset asserted while the raster sits at (5,2)
        for (int i = 0; i < NPIX + 1 && p != 2 * HT + 5; i++) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (210) step(1'b1, 1'b1);
        repeat (3) @(posedge clk_in);
        #8;
        n_cmp++;
        if (q_edge.size() + q_mid.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q_edge.size() + q_mid.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
